// File: rtl/ps2_note_pkg.sv
// Shared types and constants for the PS/2 note tracker: FSM states, prefix and
// ignore codes, octave keys and the 13-entry key-to-note table.
package ps2_note_pkg;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_e;

  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_BAT    = 8'hAA;
  localparam logic [7:0] CODE_ECHO   = 8'hEE;
  localparam logic [7:0] CODE_OCT_DN = 8'h1A;
  localparam logic [7:0] CODE_OCT_UP = 8'h22;

  localparam int KEY_CNT = 13;
  // Entry 0 is the rightmost: A,W,S,E,D,F,T,G,Y,H,U,J,K
  localparam logic [KEY_CNT-1:0][7:0] KEY_TABLE = {
    8'h42, 8'h3B, 8'h3C, 8'h33, 8'h35, 8'h34, 8'h2C,
    8'h2B, 8'h23, 8'h24, 8'h1B, 8'h1D, 8'h1C
  };

  function automatic logic is_ignored(input logic [7:0] c);
    return (c == CODE_ACK) || (c == CODE_BAT) || (c == CODE_ECHO);
  endfunction

endpackage

// File: rtl/ps2_note_lookup.sv
// Combinational scan code -> note index lookup; entries at or above NUM_NOTES
// are treated as misses.
module ps2_note_lookup
  import ps2_note_pkg::*;
#(
  parameter int NUM_NOTES = 13
) (
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = 4'd0;
    for (int i = 0; i < KEY_CNT; i++) begin
      if (i < NUM_NOTES && code == KEY_TABLE[i]) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_note_tracker.sv
// PS/2 scan-code stream to held-note bitmap plus note-on/off pulses, with
// auto-repeat suppression and prefix timeout. NOTE_TRACKER_OCTAVE_EN adds Z/X octave keys.
module ps2_note_tracker
  import ps2_note_pkg::*;
#(
  parameter int NUM_NOTES      = 13,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [7:0]           received_data,
  input  logic                 received_data_en,
  output logic [NUM_NOTES-1:0] note_held,
  output logic                 note_on,
  output logic                 note_off,
  output logic [3:0]           note_idx,
  output logic [7:0]           last_code,
  output logic [2:0]           octave
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_NOTES-1:0] held_q, held_d;
  logic                 on_q, on_d, off_q, off_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           last_q, last_d;
  logic [2:0]           oct_q, oct_d;

  logic                 lk_hit;
  logic [3:0]           lk_idx;
  logic [NUM_NOTES-1:0] sel;
  logic                 is_prefix, do_make, do_brk;

  ps2_note_lookup #(.NUM_NOTES(NUM_NOTES)) u_lookup (
    .code (received_data),
    .hit  (lk_hit),
    .idx  (lk_idx)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_NOTES; i++) sel[i] = (lk_idx == 4'(i));
  end

  assign is_prefix = (received_data == CODE_F0) || (received_data == CODE_E0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    on_d    = 1'b0;
    off_d   = 1'b0;
    idx_d   = idx_q;
    last_d  = last_q;
    oct_d   = oct_q;
    do_make = 1'b0;
    do_brk  = 1'b0;

    if (received_data_en) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (received_data == CODE_F0)      state_d = BRK;
          else if (received_data == CODE_E0) state_d = EXT;
          else if (!is_ignored(received_data)) do_make = 1'b1;
        end
        BRK: begin
          do_brk  = 1'b1;
          state_d = IDLE;
        end
        EXT:     state_d = (received_data == CODE_F0) ? EXT_BRK : IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (!is_prefix && !is_ignored(received_data)) last_d = received_data;
    end else if (state_q != IDLE) begin
      // A stalled prefix is abandoned exactly TIMEOUT_CYCLES after its byte
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Repeat makes of a held note and breaks of a released note are no-ops
    if (do_make && lk_hit && (held_q & sel) == '0) begin
      held_d = held_q | sel;
      on_d   = 1'b1;
      idx_d  = lk_idx;
    end
    if (do_brk && lk_hit && (held_q & sel) != '0) begin
      held_d = held_q & ~sel;
      off_d  = 1'b1;
      idx_d  = lk_idx;
    end

`ifdef NOTE_TRACKER_OCTAVE_EN
    if (do_make && received_data == CODE_OCT_UP && oct_q != 3'd7) oct_d = oct_q + 3'd1;
    if (do_make && received_data == CODE_OCT_DN && oct_q != 3'd0) oct_d = oct_q - 3'd1;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      on_q    <= 1'b0;
      off_q   <= 1'b0;
      idx_q   <= 4'd0;
      last_q  <= 8'd0;
      oct_q   <= 3'd4;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      on_q    <= on_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      oct_q   <= oct_d;
    end
  end

  assign note_held = held_q;
  assign note_on   = on_q;
  assign note_off  = off_q;
  assign note_idx  = idx_q;
  assign last_code = last_q;
`ifdef NOTE_TRACKER_OCTAVE_EN
  assign octave    = oct_q;
`else
  assign octave    = 3'd4;
`endif

endmodule

// File: tb/tb_ps2_note_tracker.sv
// Scoreboard bench for ps2_note_tracker: directed byte sequences push expected
// note events; a negedge monitor pops and compares on every pulse.
module tb_ps2_note_tracker;

  localparam int TO = 20;

  typedef struct {
    logic        on;
    logic [3:0]  idx;
    logic [12:0] held;
  } ev_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  data = 8'h00, data4 = 8'h00;
  logic        en = 1'b0, en4 = 1'b0;

  logic [12:0] held;
  logic        on, off;
  logic [3:0]  idx;
  logic [7:0]  last;
  logic [2:0]  oct;

  logic [3:0]  held4;
  logic        on4, off4;
  logic [3:0]  idx4;
  logic [7:0]  last4;
  logic [2:0]  oct4;

  ev_t q13[$];
  ev_t q4[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  ps2_note_tracker #(.NUM_NOTES(13), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk), .resetn(resetn), .received_data(data), .received_data_en(en),
    .note_held(held), .note_on(on), .note_off(off), .note_idx(idx),
    .last_code(last), .octave(oct)
  );

  ps2_note_tracker #(.NUM_NOTES(4), .TIMEOUT_CYCLES(TO)) dut4 (
    .CLOCK_50(clk), .resetn(resetn), .received_data(data4), .received_data_en(en4),
    .note_held(held4), .note_on(on4), .note_off(off4), .note_idx(idx4),
    .last_code(last4), .octave(oct4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    en   = 1'b1;
    @(posedge clk); #1;
    en   = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    data4 = b;
    en4   = 1'b1;
    @(posedge clk); #1;
    en4   = 1'b0;
  endtask

  task automatic expect13(input logic is_on, input logic [3:0] i, input logic [12:0] h);
    ev_t e;
    e.on = is_on; e.idx = i; e.held = h;
    q13.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the head of its queue
  always @(negedge clk) begin
    ev_t e;
    if (on && off) begin
      checks++; errors++;
      $display("FAIL on_off_same_cycle: got on=1 off=1 expected one-hot");
    end
    if (on || off) begin
      if (q13.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event13: got on=%0b off=%0b idx=%0d expected none", on, off, idx);
      end else begin
        e = q13.pop_front();
        chk("ev13_on", {31'd0, on}, {31'd0, e.on});
        chk("ev13_idx", {28'd0, idx}, {28'd0, e.idx});
        chk("ev13_held", {19'd0, held}, {19'd0, e.held});
      end
    end
    if (on4 || off4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event4: got on=%0b off=%0b idx=%0d expected none", on4, off4, idx4);
      end else begin
        e = q4.pop_front();
        chk("ev4_on", {31'd0, on4}, {31'd0, e.on});
        chk("ev4_idx", {28'd0, idx4}, {28'd0, e.idx});
        chk("ev4_held", {28'd0, held4}, {28'd0, e.held[3:0]});
      end
    end
  end

  initial begin
    ev_t e4;
    idle(3);
    chk("rst_held", {19'd0, held}, 32'h0);
    chk("rst_on_off", {30'd0, on, off}, 32'h0);
    chk("rst_idx", {28'd0, idx}, 32'h0);
    chk("rst_last", {24'd0, last}, 32'h0);
    chk("rst_octave", {29'd0, oct}, 32'd4);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(2);

    // Press and release A
    expect13(1, 0, 13'h0001); send(8'h1C);
    expect13(0, 0, 13'h0000); send(8'hF0); send(8'h1C);
    idle(2);
    chk("last_1c", {24'd0, last}, 32'h1C);
    chk("idx_holds", {28'd0, idx}, 32'd0);

    // Typematic repeat yields one note_on
    expect13(1, 0, 13'h0001); send(8'h1C); send(8'h1C); send(8'h1C);
    idle(2);
    chk("repeat_held", {19'd0, held}, 32'h0001);
    expect13(0, 0, 13'h0000); send(8'hF0); send(8'h1C);

    // Chord A,S,D; release S
    expect13(1, 0, 13'h0001); send(8'h1C);
    expect13(1, 2, 13'h0005); send(8'h1B);
    expect13(1, 4, 13'h0015); send(8'h23);
    idle(1);
    chk("chord_held", {19'd0, held}, 32'h0015);
    expect13(0, 2, 13'h0011); send(8'hF0); send(8'h1B);
    idle(2);
    chk("chord_after_rel", {19'd0, held}, 32'h0011);
    chk("chord_idx_holds", {28'd0, idx}, 32'd2);
    expect13(0, 0, 13'h0010); send(8'hF0); send(8'h1C);
    expect13(0, 4, 13'h0000); send(8'hF0); send(8'h23);

    // Extended keys never touch notes; ignore-list bytes leave last_code alone
    expect13(1, 0, 13'h0001); send(8'h1C);
    send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h1C);
    idle(2);
    chk("ext_held", {19'd0, held}, 32'h0001);
    expect13(1, 12, 13'h1001); send(8'h42);
    send(8'hFA);
    idle(2);
    chk("ack_last", {24'd0, last}, 32'h42);
    send(8'h15);
    idle(1);
    chk("unmapped_last", {24'd0, last}, 32'h15);
    chk("unmapped_held", {19'd0, held}, 32'h1001);
    expect13(0, 12, 13'h0001); send(8'hF0); send(8'h42);

    // Timeout boundary: one cycle short is still a break, full timeout is a make
    send(8'hF0); idle(TO - 1);
    expect13(0, 0, 13'h0000); send(8'h1C);
    send(8'hF0); idle(TO);
    expect13(1, 0, 13'h0001); send(8'h1C);
    expect13(0, 0, 13'h0000); send(8'hF0); send(8'h1C);

    // NUM_NOTES=4 masks higher table entries
    send4(8'h2B);
    e4.on = 1; e4.idx = 1; e4.held = 13'h0002; q4.push_back(e4);
    send4(8'h1D);
    send4(8'hF0); send4(8'h2B);
    idle(2);
    chk("n4_held", {28'd0, held4}, 32'h2);

`ifdef NOTE_TRACKER_OCTAVE_EN
    repeat (5) send(8'h22);
    idle(1);
    chk("octave_sat_hi", {29'd0, oct}, 32'd7);
    repeat (9) send(8'h1A);
    idle(1);
    chk("octave_sat_lo", {29'd0, oct}, 32'd0);
`else
    send(8'h22);
    idle(1);
    chk("octave_const", {29'd0, oct}, 32'd4);
    chk("x_unmapped_held", {19'd0, held}, 32'h0);
`endif

    // Reset mid-sequence drops held notes silently and returns FSM to IDLE
    expect13(1, 0, 13'h0001); send(8'h1C);
    expect13(1, 2, 13'h0005); send(8'h1B);
    send(8'hF0);
    resetn = 1'b0;
    #2;
    chk("mid_rst_held", {19'd0, held}, 32'h0);
    chk("mid_rst_pulses", {30'd0, on, off}, 32'h0);
    chk("mid_rst_idx", {28'd0, idx}, 32'h0);
    chk("mid_rst_last", {24'd0, last}, 32'h0);
    chk("mid_rst_octave", {29'd0, oct}, 32'd4);
    idle(2);
    resetn = 1'b1;
    idle(1);
    expect13(1, 2, 13'h0004); send(8'h1B);
    idle(4);

    chk("q13_drained", q13.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_note_tracker.md
# ps2_note_tracker

Parametrised PS/2 scan-code decoder that turns the raw byte stream from `PS2_Controller` into a polyphonic note-held bitmap plus single-cycle note-on/note-off events. It sits between `PS2_Controller` and the tone generators. It tracks make/break (`F0`) and extended (`E0`) prefixes. It also drops keyboard auto-repeat, so each physical press produces exactly one note-on.

## Interface
- `NUM_NOTES`, 13: number of tracked notes, 1..13; note index i maps to the i-th entry of the package key table.
- `TIMEOUT_CYCLES`, 150000: cycles a prefix state may wait for its follow-up byte before being abandoned (3 ms at 50 MHz).
- `CLOCK_50`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `received_data`  in  8  byte from `PS2_Controller`.
- `received_data_en`  in  1  one-cycle strobe; `received_data` is valid this cycle.
- `note_held`  out  NUM_NOTES  bit i = 1 while note i is held.
- `note_on`  out  1  one-cycle pulse when a note transitions from released to held.
- `note_off`  out  1  one-cycle pulse when a note transitions from held to released.
- `note_idx`  out  4  index of the note for the most recent `note_on`/`note_off`; holds its value between events.
- `last_code`  out  8  last non-prefix byte received.
- `octave`  out  3  current octave.

## Operation
- FSM states: `IDLE`, `BRK` (after `F0`), `EXT` (after `E0`), `EXT_BRK` (after `E0 F0`).
- `IDLE`:
  - `F0` → `BRK`.
  - `E0` → `EXT`.
  - `FA`/`AA`/`EE` (ack/BAT/echo) are ignored.
  - Any other byte is a make.
- `BRK`: any byte is a break, then → `IDLE`.
- `EXT`:
  - `F0` → `EXT_BRK`.
  - Any other byte → `IDLE`, with no note action.
- `EXT_BRK`: any byte → `IDLE`, with no note action. Extended keys never affect notes.
- Make of a mapped code with index < NUM_NOTES:
  - If the note is not held: set its bit, pulse `note_on`, load `note_idx`.
  - If the note is already held (typematic repeat): no change, no pulse.
- Break of a mapped code:
  - If the note is held: clear its bit, pulse `note_off`, load `note_idx`.
  - Otherwise: nothing.
- Unmapped codes only update `last_code`.
- Timeout:
  - A counter runs while the FSM is in any non-`IDLE` state and clears on every `received_data_en`.
  - On reaching TIMEOUT_CYCLES−1, the FSM returns to `IDLE` and the partial sequence is discarded.
  - If `received_data_en` and expiry occur in the same cycle, the byte wins: it is processed in the current state.
- Reset values: `note_held`=0, `note_on`=0, `note_off`=0, `note_idx`=0, `last_code`=0, `octave`=4, FSM=`IDLE`, counter=0.
- Reset mid-sequence drops all held notes without emitting `note_off` pulses.

## Timing
- All outputs are registered.
- Effect of a `received_data_en` cycle is visible on the next rising edge: 1-cycle latency.
- Only one byte is accepted per strobe. `note_on` and `note_off` are never high in the same cycle.
- Back-to-back strobes on consecutive cycles are fully supported.
- Timeout resolution is exactly TIMEOUT_CYCLES cycles after the last prefix byte.

## Configuration
- `NOTE_TRACKER_OCTAVE_EN` defined:
  - Makes of `1A` (Z) and `22` (X) decrement/increment `octave`, saturating at 0 and 7.
  - Auto-repeat makes also step the octave.
  - Z/X are excluded from the note table.
- Not defined:
  - `octave` is a constant 4.
  - Z/X are plain unmapped codes.

## Structure
- Package `ps2_note_pkg`:
  - FSM state enum.
  - Prefix constants `F0`/`E0`.
  - Ignore-list constants.
  - Octave key codes.
  - 13-entry key table in order A,W,S,E,D,F,T,G,Y,H,U,J,K = `1C,1D,1B,24,23,2B,2C,34,35,33,3C,3B,42`.
- One sub-module `ps2_note_lookup`: combinational code → {hit, index}, masked by NUM_NOTES.

## Test plan
- `1C` then `F0 1C` → `note_on` pulse with `note_idx`=0 and `note_held[0]`=1; then `note_off` pulse with `note_held[0]`=0.
- `1C 1C 1C` (auto-repeat) → exactly one `note_on`; `note_held`=`13'h0001`.
- `1C 1B 23` held, then `F0 1B` → `note_held`=`13'h0015`, then `13'h0011`; `note_off` carries `note_idx`=2.
- `E0 1C`, then `E0 F0 1C` → no pulses and `note_held` unchanged. Also `FA` in `IDLE` → `last_code` unchanged.
- `F0`, then idle for TIMEOUT_CYCLES, then `1C` → treated as a make: `note_on` with idx 0. Also NUM_NOTES=4 with `2B` (idx 5) → no pulse.
- With `NOTE_TRACKER_OCTAVE_EN`: `22` ×5 → `octave`=7 (saturated); `1A` ×9 → `octave`=0. Reset asserted with notes held → all outputs return to reset values, `octave`=4.
